// File: rtl/lock_key_loader.sv
// Serial key loader for the XOR-locked c432 core: shifts in a key frame LSB first,
// verifies it and holds the key on keyinput. Optional parity check: KEYLD_PARITY_EN.
module lock_key_loader #(
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_clear,
  input  logic             key_sdi,
  input  logic             key_sden,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);

`ifdef KEYLD_PARITY_EN
  localparam int FRAME_W = KEY_W + 1;
`else
  localparam int FRAME_W = KEY_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] KEY_BITS = CNT_W'(KEY_W);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CHECK, S_LOCKED, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] active_q, active_d;
  logic             key_valid_q, key_valid_d;
  logic             busy_q, busy_d;
  logic             check_ok;

`ifdef KEYLD_PARITY_EN
  logic parity_q, parity_d;
  logic key_err_q, key_err_d;
  // Even parity over the whole frame: the accumulated XOR must be zero.
  assign check_ok = ~parity_q;
`else
  assign check_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
`ifdef KEYLD_PARITY_EN
    parity_d = parity_q;
`endif
    if (key_clear) begin
      state_d  = S_IDLE;
      active_d = '0;
    end else if (key_start) begin
      // Any restart re-locks the core until the new frame verifies.
      state_d  = S_SHIFT;
      cnt_d    = '0;
      shadow_d = '0;
      active_d = '0;
`ifdef KEYLD_PARITY_EN
      parity_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          if (key_sden) begin
            if (cnt_q < KEY_BITS)
              shadow_d = {key_sdi, shadow_q[KEY_W-1:1]};
`ifdef KEYLD_PARITY_EN
            parity_d = parity_q ^ key_sdi;
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT)
              state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (check_ok) begin
            active_d = shadow_q;
            state_d  = S_LOCKED;
          end else begin
            state_d  = S_ERROR;
          end
        end
        default: ;
      endcase
    end

    // Status flags are registered from the next state so they track it exactly.
    key_valid_d = (state_d == S_LOCKED);
    busy_d      = (state_d == S_SHIFT) || (state_d == S_CHECK);
`ifdef KEYLD_PARITY_EN
    key_err_d   = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef KEYLD_PARITY_EN
      parity_q    <= 1'b0;
      key_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
`ifdef KEYLD_PARITY_EN
      parity_q    <= parity_d;
      key_err_q   <= key_err_d;
`endif
    end
  end

  assign keyinput  = active_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
`ifdef KEYLD_PARITY_EN
  assign key_err   = key_err_q;
`else
  assign key_err   = 1'b0;
`endif

endmodule
